// File: rtl/mult_sched_pkg.sv
// mult_sched_pkg: shared constants, types and helpers for mult_scheduler.
//   id_width(n) : requester-index width, never narrower than 1 bit.
//   res_t       : tagged result {id, product} for the default build widths.
package mult_sched_pkg;

    function automatic int id_width(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++)
            if ((1 << i) < n) w = i + 1;
        return w;
    endfunction

    localparam int DEF_P     = 8;
    localparam int DEF_N_REQ = 4;
    localparam int DEF_ID_W  = id_width(DEF_N_REQ);

    typedef struct packed {
        logic [DEF_ID_W-1:0] id;
        logic [2*DEF_P-1:0]  product;
    } res_t;

endpackage

// File: rtl/multiplier.sv
// multiplier: combinational unsigned P x P -> 2P multiplier.
//   a, b    : operands (P bits each)
//   product : full 2P-bit unsigned product
// ARCH_TYPE 0 leaves the structure to synthesis; 1 builds a carry-save
// array (one 3:2 compressor row per multiplier bit, then one final adder).
module multiplier #(
    parameter int parallelism = 8,
    parameter int ARCH_TYPE   = 0
) (
    input  logic [parallelism-1:0]   a,
    input  logic [parallelism-1:0]   b,
    output logic [2*parallelism-1:0] product
);
    localparam int PW = 2 * parallelism;

    if (ARCH_TYPE == 0) begin : g_behav
        assign product = {{parallelism{1'b0}}, a} * {{parallelism{1'b0}}, b};
    end else begin : g_csa
        logic [PW-1:0] sum_v, car_v, pp, nsum, ncar;
        always_comb begin
            sum_v = '0;
            car_v = '0;
            pp    = '0;
            nsum  = '0;
            ncar  = '0;
            for (int i = 0; i < parallelism; i++) begin
                pp    = b[i] ? ({{parallelism{1'b0}}, a} << i) : '0;
                nsum  = sum_v ^ car_v ^ pp;
                // The product never exceeds 2P bits, so the carry shifted
                // out of the top is always zero.
                ncar  = ((sum_v & car_v) | (sum_v & pp) | (car_v & pp)) << 1;
                sum_v = nsum;
                car_v = ncar;
            end
        end
        assign product = sum_v + car_v;
    end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant over N_REQ requests.
//   clk, rst  : clock, synchronous active-high reset
//   req       : request vector
//   advance   : the current grant was taken; move pointer past it
//   grant     : one-hot grant (zero when no request)
//   grant_idx : index of the granted request
// Search starts at rr_ptr and wraps at N_REQ-1, so unused pointer codes
// of a non-power-of-two N_REQ are never visited.
module rr_arbiter
    import mult_sched_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int ID_W  = id_width(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             advance,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx
);
    logic [ID_W-1:0] rr_ptr;
    logic            found;
    int              j;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        j         = 0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (!found && req[j]) begin
                found     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = j[ID_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            rr_ptr <= '0;
        else if (advance)
            rr_ptr <= (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + ID_W'(1);
    end
endmodule

// File: rtl/mult_scheduler.sv
// mult_scheduler: one shared multiplier, round-robin over N_REQ requesters.
//   clk, rst              : clock, synchronous active-high reset
//   req_valid/req_ready   : per-requester handshake (ready one-hot or zero)
//   req_a, req_b          : packed operands, requester k at [k*P +: P]
//   res_valid/res_ready   : result handshake
//   res_id, res_product   : requester tag and full 2P-bit product
// Pipeline: S1 operand register -> combinational multiplier -> S2 output
// register. A result appears two edges after its operands were accepted.
module mult_scheduler
    import mult_sched_pkg::*;
#(
    parameter  int parallelism = 8,
    parameter  int N_REQ       = 4,
    parameter  int ARCH_TYPE   = 0,
    localparam int ID_W        = id_width(N_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req_valid,
    output logic [N_REQ-1:0]             req_ready,
    input  logic [N_REQ*parallelism-1:0] req_a,
    input  logic [N_REQ*parallelism-1:0] req_b,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [ID_W-1:0]              res_id,
    output logic [2*parallelism-1:0]     res_product
);
    typedef struct packed {
        logic [ID_W-1:0]          id;
        logic [2*parallelism-1:0] product;
    } sched_res_t;

    logic [N_REQ-1:0]         grant;
    logic [ID_W-1:0]          grant_idx;
    logic                     s2_en, s1_free, xfer;
    logic                     s1_valid;
    logic [ID_W-1:0]          s1_id;
    logic [parallelism-1:0]   s1_a, s1_b, sel_a, sel_b;
    logic [2*parallelism-1:0] s1_product;
    sched_res_t               res_q;

    assign s2_en   = !res_valid || res_ready;
    assign s1_free = !s1_valid || s2_en;
    // Grant only reaches the requester when S1 can take it; held off in reset.
    assign req_ready = (rst || !s1_free) ? '0 : grant;
    assign xfer      = |req_ready;

    assign sel_a = req_a[grant_idx*parallelism +: parallelism];
    assign sel_b = req_b[grant_idx*parallelism +: parallelism];

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .advance   (xfer),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_id    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (xfer) begin
            s1_valid <= 1'b1;
            s1_id    <= grant_idx;
            s1_a     <= sel_a;
            s1_b     <= sel_b;
        end else if (s2_en) begin
            s1_valid <= 1'b0;
        end
    end

    multiplier #(.parallelism(parallelism), .ARCH_TYPE(ARCH_TYPE)) u_mul (
        .a       (s1_a),
        .b       (s1_b),
        .product (s1_product)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_q     <= '0;
        end else if (s2_en) begin
            res_valid <= s1_valid;
            res_q     <= '{id: s1_id, product: s1_product};
        end
    end

    assign res_id      = res_q.id;
    assign res_product = res_q.product;
endmodule
